// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage with a PC generator, a 1-cycle-latency
//            imem interface and a small response queue. The optional BTB is
//            enabled by defining FETCH_BTB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QDEPTH      = 2,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_btb_upd_valid,
    input  logic [31:0] i_btb_upd_pc,
    input  logic [31:0] i_btb_upd_target,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_pred_taken
);

    localparam int          QW        = $clog2(QDEPTH);
    localparam int          CW        = QW + 1;
    localparam logic [31:0] C_NOP     = 32'h0000_0013;
    localparam logic [CW:0] C_QDEPTH  = (CW + 1)'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   infl_pc_q, infl_pc_d;
    logic          infl_pred_q, infl_pred_d;
    logic [QW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_pc_q    [QDEPTH];
    logic [31:0]   fifo_pc_d    [QDEPTH];
    logic [31:0]   fifo_instr_q [QDEPTH];
    logic [31:0]   fifo_instr_d [QDEPTH];
    logic          fifo_pred_q  [QDEPTH];
    logic          fifo_pred_d  [QDEPTH];

    logic          w_valid;
    logic          w_deq;
    logic          w_enq;
    logic [CW:0]   w_occ;
    logic          w_issue;
    logic [31:0]   w_issue_addr;
    logic [QW-1:0] w_tail;
    logic          w_hit;
    logic [31:0]   w_target;

    assign w_valid      = (count_q != '0);
    assign w_deq        = w_valid & ~i_stall & ~i_redirect;
    // A response landing in the same cycle as a redirect belongs to the old path.
    assign w_enq        = inflight_q & ~i_redirect;
    assign w_occ        = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(w_deq);
    assign w_issue      = i_reset & (i_redirect | (w_occ < C_QDEPTH));
    assign w_issue_addr = i_redirect ? {i_redirect_pc[31:2], 2'b00} : fetch_pc_q;
    assign w_tail       = head_q + count_q[QW-1:0];

    assign o_imem_req   = w_issue;
    assign o_imem_addr  = w_issue_addr;
    assign o_valid      = w_valid;
    assign o_pc         = w_valid ? fifo_pc_q[head_q]    : 32'h0;
    assign o_instr      = w_valid ? fifo_instr_q[head_q] : C_NOP;
    assign o_pred_taken = w_valid & fifo_pred_q[head_q];

`ifdef FETCH_BTB_EN
    localparam int BI = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - BI;

    logic          btb_valid_q [BTB_ENTRIES];
    logic          btb_valid_d [BTB_ENTRIES];
    logic [TW-1:0] btb_tag_q   [BTB_ENTRIES];
    logic [TW-1:0] btb_tag_d   [BTB_ENTRIES];
    logic [29:0]   btb_tgt_q   [BTB_ENTRIES];
    logic [29:0]   btb_tgt_d   [BTB_ENTRIES];
    logic [BI-1:0] w_lk_idx;
    logic [BI-1:0] w_up_idx;
    logic          w_unused_btb;

    assign w_lk_idx     = w_issue_addr[BI+1:2];
    assign w_up_idx     = i_btb_upd_pc[BI+1:2];
    // Lookup reads the registered arrays, so a same-cycle update is not seen.
    assign w_hit        = btb_valid_q[w_lk_idx] & (btb_tag_q[w_lk_idx] == w_issue_addr[31:BI+2]);
    assign w_target     = {btb_tgt_q[w_lk_idx], 2'b00};
    assign w_unused_btb = ^{i_redirect_pc[1:0], i_btb_upd_pc[1:0], i_btb_upd_target[1:0]};

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        if (i_btb_upd_valid) begin
            btb_valid_d[w_up_idx] = 1'b1;
            btb_tag_d[w_up_idx]   = i_btb_upd_pc[31:BI+2];
            btb_tgt_d[w_up_idx]   = i_btb_upd_target[31:2];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
        end else begin
            btb_valid_q <= btb_valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        btb_tag_q <= btb_tag_d;
        btb_tgt_q <= btb_tgt_d;
    end
`else
    logic w_unused_btb;

    assign w_hit        = 1'b0;
    assign w_target     = 32'h0;
    assign w_unused_btb = ^{i_redirect_pc[1:0], i_btb_upd_valid, i_btb_upd_pc,
                            i_btb_upd_target, (BTB_ENTRIES != 0)};
`endif

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = w_issue;
        infl_pc_d   = infl_pc_q;
        infl_pred_d = infl_pred_q;
        if (w_issue) begin
            fetch_pc_d  = w_hit ? w_target : (w_issue_addr + 32'd4);
            infl_pc_d   = w_issue_addr;
            infl_pred_d = w_hit;
        end
    end

    always_comb begin
        head_d       = head_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pred_d  = fifo_pred_q;
        if (i_redirect) begin
            head_d  = '0;
            count_d = '0;
        end else begin
            if (w_deq) head_d = head_q + QW'(1);
            // Issue throttling guarantees the tail slot is free whenever a response arrives.
            if (w_enq) begin
                fifo_pc_d[w_tail]    = infl_pc_q;
                fifo_instr_d[w_tail] = i_imem_rdata;
                fifo_pred_d[w_tail]  = infl_pred_q;
            end
            count_d = count_q + CW'(w_enq) - CW'(w_deq);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= 1'b0;
            infl_pc_q   <= 32'h0;
            infl_pred_q <= 1'b0;
            head_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0;
                fifo_instr_q[i] <= C_NOP;
                fifo_pred_q[i]  <= 1'b0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            infl_pc_q    <= infl_pc_d;
            infl_pred_q  <= infl_pred_d;
            head_q       <= head_d;
            count_q      <= count_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pred_q  <= fifo_pred_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed, table-driven self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int QDEPTH = 2;
`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] upd_pc;
        logic [31:0] upd_tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic        pred;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] pc, instr;
    logic        valid, pred;

    int   checks = 0;
    int   errors = 0;
    int   occ_model;
    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QDEPTH), .BTB_ENTRIES(16)) dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_stall         (stall),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_rdata    (imem_rdata),
        .i_btb_upd_valid (upd_valid),
        .i_btb_upd_pc    (upd_pc),
        .i_btb_upd_target(upd_target),
        .o_pc            (pc),
        .o_instr         (instr),
        .o_valid         (valid),
        .o_pred_taken    (pred)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h1357_9BD0;
    endfunction

    // Synchronous instruction memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_word(imem_addr);
    end

    // Requests issued but not yet consumed (queue entries + in-flight).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        occ_model <= 0;
        else if (redirect) occ_model <= imem_req ? 1 : 0;
        else               occ_model <= occ_model + (imem_req ? 1 : 0)
                                      - ((valid && !stall) ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rq, input logic [31:0] ad,
                       input logic vl, input logic [31:0] p, input logic pr);
        vecs.push_back('{stall:st, redir:rd, rpc:rpc, upd:1'b0, upd_pc:32'h0, upd_tgt:32'h0,
                         req:rq, addr:ad, valid:vl, pc:p, pred:pr});
    endtask

    // Applied at a falling edge; outputs are sampled 1 ns later, mid-cycle.
    task automatic apply(input vec_t v, input int idx);
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        upd_valid   = v.upd;
        upd_pc      = v.upd_pc;
        upd_target  = v.upd_tgt;
        #1;
        chk($sformatf("v%0d req", idx), {31'h0, imem_req}, {31'h0, v.req});
        if (v.req) chk($sformatf("v%0d addr", idx), imem_addr, v.addr);
        chk($sformatf("v%0d valid", idx), {31'h0, valid}, {31'h0, v.valid});
        chk($sformatf("v%0d pc", idx), pc, v.valid ? v.pc : 32'h0);
        chk($sformatf("v%0d instr", idx), instr, v.valid ? imem_word(v.pc) : 32'h13);
        chk($sformatf("v%0d pred", idx), {31'h0, pred}, {31'h0, v.pred});
        chk($sformatf("v%0d occupancy", idx), {31'h0, occ_model <= QDEPTH}, 32'h1);
        @(negedge clk);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) apply(vecs[i], i);
        vecs.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, " valid"}, {31'h0, valid},    32'h0);
        chk({tag, " pc"},    pc,                32'h0);
        chk({tag, " instr"}, instr,             32'h13);
        chk({tag, " pred"},  {31'h0, pred},     32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, 5-cycle stall at 0x10, redirects (full queue, with stall, unaligned), wrap.
        add(0,0,0,            1,32'h0,        0,32'h0,        0);
        add(0,0,0,            1,32'h4,        0,32'h0,        0);
        add(0,0,0,            1,32'h8,        1,32'h0,        0);
        add(0,0,0,            1,32'hC,        1,32'h4,        0);
        add(0,0,0,            1,32'h10,       1,32'h8,        0);
        add(0,0,0,            1,32'h14,       1,32'hC,        0);
        for (int k = 0; k < 5; k++) add(1,0,0, 0,32'h0, 1,32'h10, 0);
        add(0,0,0,            1,32'h18,       1,32'h10,       0);
        add(0,0,0,            1,32'h1C,       1,32'h14,       0);
        add(0,0,0,            1,32'h20,       1,32'h18,       0);
        add(1,0,0,            0,32'h0,        1,32'h1C,       0);
        add(0,1,32'h100,      1,32'h100,      1,32'h1C,       0);
        add(0,0,0,            1,32'h104,      0,32'h0,        0);
        add(0,0,0,            1,32'h108,      1,32'h100,      0);
        add(0,0,0,            1,32'h10C,      1,32'h104,      0);
        add(1,1,32'h202,      1,32'h200,      1,32'h108,      0);
        add(0,0,0,            1,32'h204,      0,32'h0,        0);
        add(0,0,0,            1,32'h208,      1,32'h200,      0);
        add(0,0,0,            1,32'h20C,      1,32'h204,      0);
        add(0,1,32'hFFFF_FFF8,1,32'hFFFF_FFF8,1,32'h208,      0);
        add(0,0,0,            1,32'hFFFF_FFFC,0,32'h0,        0);
        add(0,0,0,            1,32'h0,        1,32'hFFFF_FFF8,0);
        add(0,0,0,            1,32'h4,        1,32'hFFFF_FFFC,0);
        add(0,0,0,            1,32'h8,        1,32'h0,        0);
        run_vecs();

        // Asynchronous reset between edges while the queue holds entries.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart from RESET_PC, BTB install 0x8 -> 0x40 in the first cycle.
        add(0,0,0, 1,32'h0, 0,32'h0, 0);
        vecs[0].upd     = 1'b1;
        vecs[0].upd_pc  = 32'h8;
        vecs[0].upd_tgt = 32'h40;
        add(0,0,0, 1,32'h4, 0,32'h0, 0);
        add(0,0,0, 1,32'h8, 1,32'h0, 0);
        add(0,0,0, 1,BTB_ON ? 32'h40 : 32'hC,  1,32'h4, 0);
        add(0,0,0, 1,BTB_ON ? 32'h44 : 32'h10, 1,32'h8, BTB_ON);
        add(0,0,0, 1,BTB_ON ? 32'h48 : 32'h14, 1,BTB_ON ? 32'h40 : 32'hC,  0);
        add(0,0,0, 1,BTB_ON ? 32'h4C : 32'h18, 1,BTB_ON ? 32'h44 : 32'h10, 0);
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
